// File: rtl/ipv4_hdr_parser.sv
// IPv4 header parser: walks the 20-byte header, checks version/IHL, checksum and length,
// captures the key fields and forwards the payload with exactly one cycle of latency.
module ipv4_hdr_parser (
   input  logic        clk_i,
   input  logic        rst,
   input  logic [7:0]  rx_d,
   input  logic        rx_dv,
   input  logic        rx_sof,
   input  logic        rx_eof,
   output logic [7:0]  csum_d,
   output logic        csum_en,
   output logic        csum_rst,
   output logic        hdr_done,
   output logic        hdr_ok,
   output logic [31:0] src_ip,
   output logic [31:0] dst_ip,
   output logic [7:0]  proto,
   output logic [15:0] total_len,
   output logic        is_udp,
   output logic [7:0]  pay_d,
   output logic        pay_dv,
   output logic        err
);

   // Handshake: valid-only stream, no backpressure. A byte is accepted on every rising edge
   // with rx_dv=1; rx_sof/rx_eof mean nothing without rx_dv. Outputs pulse one cycle later.
   typedef enum logic [1:0] {IDLE, HDR, PAY, DROP} state_t;

   state_t      state, state_nx;
   logic [4:0]  idx;
   logic [7:0]  hi_q;
   logic [7:0]  byte0_q;
   logic [15:0] sum_q;
   logic [15:0] remaining;
   logic [16:0] word_sum;
   logic [15:0] sum_fold;
   logic        sof;
   logic        hdr_byte;
   logic        hdr_last;
   logic        verdict;

   assign sof      = rx_dv & rx_sof;
   assign hdr_byte = rx_dv & ~rx_sof & (state == HDR);
   assign hdr_last = hdr_byte & (idx == 5'd19);
   assign csum_rst = rst | sof;

   // Held high byte joins the current odd byte; the carry folds back without overflowing.
   assign word_sum = {1'b0, sum_q} + {1'b0, hi_q, rx_d};
   assign sum_fold = word_sum[15:0] + {15'd0, word_sum[16]};
   assign verdict  = (byte0_q == 8'h45) && (sum_fold == 16'hFFFF) && (total_len >= 16'd20);

   always_ff @(posedge clk_i) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (sof) begin
         state_nx = HDR;
      end else if (rx_dv) begin
         case (state)
            HDR: begin
               if (idx == 5'd19) begin
                  if (rx_eof)                                state_nx = IDLE;
                  else if (!verdict || total_len == 16'd20) state_nx = DROP;
                  else                                       state_nx = PAY;
               end else if (rx_eof) begin
                  state_nx = IDLE;
               end
            end
            PAY: begin
               if (rx_eof)                   state_nx = IDLE;
               else if (remaining <= 16'd1) state_nx = DROP;
            end
            DROP: if (rx_eof) state_nx = IDLE;
            default: state_nx = state;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst) begin
         idx       <= '0;
         hi_q      <= '0;
         byte0_q   <= '0;
         sum_q     <= '0;
         remaining <= '0;
         csum_d    <= '0;
         csum_en   <= 1'b0;
         hdr_done  <= 1'b0;
         hdr_ok    <= 1'b0;
         is_udp    <= 1'b0;
         err       <= 1'b0;
         src_ip    <= '0;
         dst_ip    <= '0;
         proto     <= '0;
         total_len <= '0;
         pay_d     <= '0;
         pay_dv    <= 1'b0;
      end else begin
         csum_en  <= 1'b0;
         hdr_done <= 1'b0;
         err      <= 1'b0;
         pay_dv   <= 1'b0;
         if (sof) begin
            idx       <= 5'd1;
            hi_q      <= rx_d;
            byte0_q   <= rx_d;
            sum_q     <= '0;
            remaining <= '0;
            csum_d    <= rx_d;
            csum_en   <= 1'b1;
            hdr_ok    <= 1'b0;
            is_udp    <= 1'b0;
         end else if (hdr_byte) begin
            csum_d  <= rx_d;
            csum_en <= 1'b1;
            idx     <= idx + 5'd1;
            if (!idx[0]) hi_q  <= rx_d;
            else         sum_q <= sum_fold;
            case (idx)
               5'd2:  total_len[15:8] <= rx_d;
               5'd3:  total_len[7:0]  <= rx_d;
               5'd9:  proto           <= rx_d;
               5'd12: src_ip[31:24]   <= rx_d;
               5'd13: src_ip[23:16]   <= rx_d;
               5'd14: src_ip[15:8]    <= rx_d;
               5'd15: src_ip[7:0]     <= rx_d;
               5'd16: dst_ip[31:24]   <= rx_d;
               5'd17: dst_ip[23:16]   <= rx_d;
               5'd18: dst_ip[15:8]    <= rx_d;
               5'd19: dst_ip[7:0]     <= rx_d;
               default: ;
            endcase
            if (hdr_last) begin
               hdr_done  <= 1'b1;
               hdr_ok    <= verdict;
               is_udp    <= verdict && (proto == 8'h11);
               err       <= !verdict;
               remaining <= total_len - 16'd20;
               idx       <= '0;
            end else if (rx_eof) begin
               err <= 1'b1;
               idx <= '0;
            end
         end else if (rx_dv && state == PAY && remaining != 16'd0) begin
            pay_d     <= rx_d;
            pay_dv    <= 1'b1;
            remaining <= remaining - 16'd1;
         end
      end
   end

endmodule
